// File: rtl/hash_digest_capture.sv
// Passive dmem-write snoop that captures the 8-word SHA-256 digest and presents it for display.
// Optional feature macro HASH_SCROLL_EN: rotates the displayed word every SCROLL_CYCLES clocks.
module hash_digest_capture #(
  parameter logic [11:0] BASE_ADDR     = 12'd1000,
  parameter logic [11:0] DONE_ADDR     = 12'd1008,
  parameter int unsigned SCROLL_CYCLES = 100_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wren,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  output logic        finished,
  output logic [31:0] hash_value,
  output logic [2:0]  word_index,
  output logic        error
);

  logic [31:0] dig_q [0:7];
  logic [7:0]  valid_q;
  logic        finished_q;
  logic        error_q;
  logic [31:0] hash_q, hash_d;

  logic [11:0] off;
  logic [2:0]  cap_idx;
  logic        cap_hit;
  logic        done_hit;
  logic        complete;
  logic        unused_addr_hi;

  // Only the low 12 address bits participate in decoding.
  assign unused_addr_hi = ^address_dmem[31:12];

  assign off      = address_dmem[11:0] - BASE_ADDR;
  assign cap_idx  = off[2:0];
  assign cap_hit  = wren && !finished_q && (off < 12'd8);
  assign done_hit = wren && !finished_q && (address_dmem[11:0] == DONE_ADDR) && (data != 32'd0);
  assign complete = done_hit && (valid_q == 8'hFF);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) dig_q[i] <= 32'd0;
      valid_q <= 8'd0;
    end else if (cap_hit) begin
      dig_q[cap_idx]   <= data;
      valid_q[cap_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      finished_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      if (complete) finished_q <= 1'b1;
      if (done_hit && !complete) error_q <= 1'b1;
    end
  end

`ifdef HASH_SCROLL_EN
  localparam int CNT_W = (SCROLL_CYCLES > 2) ? $clog2(SCROLL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCROLL_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       widx_q, widx_d, widx_nx;

  assign widx_nx = widx_q + 3'd1;

  // Completion loads word 0 directly so the display needs no extra settle cycle.
  always_comb begin
    cnt_d  = cnt_q;
    widx_d = widx_q;
    hash_d = hash_q;
    if (complete) begin
      cnt_d  = '0;
      widx_d = 3'd0;
      hash_d = dig_q[0];
    end else if (finished_q) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        widx_d = widx_nx;
        hash_d = dig_q[widx_nx];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      widx_q <= 3'd0;
      hash_q <= 32'd0;
    end else begin
      cnt_q  <= cnt_d;
      widx_q <= widx_d;
      hash_q <= hash_d;
    end
  end

  assign word_index = widx_q;
`else
  always_comb begin
    hash_d = hash_q;
    if (complete) hash_d = dig_q[0];
  end

  always_ff @(posedge clock) begin
    if (reset) hash_q <= 32'd0;
    else       hash_q <= hash_d;
  end

  assign word_index = 3'd0;
`endif

  assign finished   = finished_q;
  assign error      = error_q;
  assign hash_value = hash_q;

endmodule

// File: tb/tb_hash_digest_capture.sv
// Directed bench for hash_digest_capture: elapsed-time reference model plus literal spot checks.
module tb_hash_digest_capture;

  localparam int S    = 4;
  localparam int BASE = 1000;
  localparam int DONE = 1008;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wren = 1'b0;
  logic [31:0] address_dmem = 32'd0;
  logic [31:0] data = 32'd0;
  logic        finished;
  logic [31:0] hash_value;
  logic [2:0]  word_index;
  logic        error;

  hash_digest_capture #(
    .BASE_ADDR    (12'd1000),
    .DONE_ADDR    (12'd1008),
    .SCROLL_CYCLES(S)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .wren        (wren),
    .address_dmem(address_dmem),
    .data        (data),
    .finished    (finished),
    .hash_value  (hash_value),
    .word_index  (word_index),
    .error       (error)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

`ifdef HASH_SCROLL_EN
  localparam bit SCROLL = 1'b1;
`else
  localparam bit SCROLL = 1'b0;
`endif

  // Reference model: digest words, which words have been seen, and cycles elapsed since completion.
  logic [31:0] m_buf [0:7];
  bit          m_seen [0:7];
  bit          m_fin = 1'b0;
  bit          m_err = 1'b0;
  int          m_since = 0;
  bit          chk_en = 1'b0;

  always @(posedge clock) begin
    int a;
    bit all_seen;
    a = int'(address_dmem[11:0]);
    all_seen = 1'b1;
    for (int i = 0; i < 8; i++) if (!m_seen[i]) all_seen = 1'b0;
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        m_buf[i]  <= 32'd0;
        m_seen[i] <= 1'b0;
      end
      m_fin   <= 1'b0;
      m_err   <= 1'b0;
      m_since <= 0;
    end else if (m_fin) begin
      m_since <= m_since + 1;
    end else if (wren) begin
      if (a >= BASE && a < BASE + 8) begin
        m_buf[a - BASE]  <= data;
        m_seen[a - BASE] <= 1'b1;
      end else if (a == DONE && data != 32'd0) begin
        if (all_seen) begin
          m_fin   <= 1'b1;
          m_since <= 0;
        end else begin
          m_err <= 1'b1;
        end
      end
    end
  end

  always @(negedge clock) begin
    int idx;
    if (chk_en) begin
      idx = SCROLL ? ((m_since / S) % 8) : 0;
      check("model_finished", {31'd0, finished}, {31'd0, m_fin});
      check("model_error", {31'd0, error}, {31'd0, m_err});
      check("model_word_index", {29'd0, word_index}, m_fin ? idx : 0);
      check("model_hash_value", hash_value, m_fin ? m_buf[idx] : 32'd0);
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wren = 1'b1;
    address_dmem = a;
    data = d;
    @(negedge clock);
    wren = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic expect_zero(input string tag);
    check({tag, "_finished"}, {31'd0, finished}, 32'd0);
    check({tag, "_hash"}, hash_value, 32'd0);
    check({tag, "_idx"}, {29'd0, word_index}, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
  endtask

  logic [31:0] abc [0:7];
  logic [31:0] alt [0:7];

  initial begin
    abc[0] = 32'hba7816bf; abc[1] = 32'h8f01cfea; abc[2] = 32'h414140de; abc[3] = 32'h5dae2223;
    abc[4] = 32'hb00361a3; abc[5] = 32'h96177a9c; abc[6] = 32'hb410ff61; abc[7] = 32'hf20015ad;
    for (int i = 0; i < 8; i++) alt[i] = 32'h1000_0001 * (i + 1);

    @(negedge clock);
    do_reset();
    chk_en = 1'b1;
    idle(10);
    expect_zero("reset_idle");

    // DONE with zero data and a stray nonzero write are both ignored.
    wr(DONE, 32'd0);
    wr(DONE + 1, 32'h5555_aaaa);
    wr(BASE - 1, 32'h1234_5678);
    check("ignored_error", {31'd0, error}, 32'd0);

    // Word 0 via an address whose upper bits are set; only [11:0] decode.
    wr(32'h0001_0000 | BASE, abc[0]);
    for (int i = 1; i < 8; i++) wr(BASE + i, abc[i]);
    check("pre_done_finished", {31'd0, finished}, 32'd0);
    wr(DONE, 32'd1);
    check("done_finished", {31'd0, finished}, 32'd1);
    check("done_hash", hash_value, 32'hba7816bf);
    check("done_idx", {29'd0, word_index}, 32'd0);

    idle(S - 1);
    check("hold_word0", hash_value, 32'hba7816bf);
    idle(1);
    check("scroll_word1", hash_value, SCROLL ? 32'h8f01cfea : 32'hba7816bf);
    idle(6 * S);
    check("scroll_word7", hash_value, SCROLL ? 32'hf20015ad : 32'hba7816bf);
    check("scroll_idx7", {29'd0, word_index}, SCROLL ? 32'd7 : 32'd0);
    idle(S);
    check("wrap_word0", hash_value, 32'hba7816bf);
    check("wrap_idx0", {29'd0, word_index}, 32'd0);

    // Locked: writes after completion change nothing (since = 33 after this write).
    wr(BASE, 32'hDEADBEEF);
    wr(DONE, 32'd1);
    idle(8 * S - 2);
    check("lock_word0", hash_value, 32'hba7816bf);
    check("lock_error", {31'd0, error}, 32'd0);

    idle(5);
    do_reset();
    expect_zero("reset_scroll");

    for (int i = 0; i < 7; i++) wr(BASE + i, abc[i]);
    wr(DONE, 32'd1);
    check("early_error", {31'd0, error}, 32'd1);
    check("early_finished", {31'd0, finished}, 32'd0);
    wr(BASE + 7, abc[7]);
    wr(DONE, 32'd1);
    check("late_finished", {31'd0, finished}, 32'd1);
    check("late_error", {31'd0, error}, 32'd1);
    check("late_hash", hash_value, 32'hba7816bf);
    idle(2 * S + 1);

    do_reset();
    for (int i = 0; i < 4; i++) wr(BASE + i, abc[i]);
    do_reset();
    expect_zero("reset_capture");
    // Words are written out of order and word 2 is rewritten before completion.
    for (int i = 7; i >= 0; i--) wr(BASE + i, alt[i]);
    wr(BASE + 2, 32'hCAFE_F00D);
    alt[2] = 32'hCAFE_F00D;
    wr(DONE, 32'h8000_0000);
    check("fresh_finished", {31'd0, finished}, 32'd1);
    check("fresh_hash", hash_value, 32'h1000_0001);
    idle(2 * S);
    check("fresh_word2", hash_value, SCROLL ? 32'hCAFE_F00D : 32'h1000_0001);
    idle(8 * S);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
